// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter in front of a single shared slave.
// Master 0 is the CPU, master 1 the host port. Ownership is locked for as long
// as the owner holds cyc, and a stall watchdog aborts transfers the slave never
// acknowledges.
module wb_arbiter2 #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  // master 0 (CPU)
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack,
  // master 1 (host port)
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack,
  // shared slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [DW/8-1:0] s_sel,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack,
  // control / status
  input  logic            prio_host,
  output logic [1:0]      grant,
  output logic            timeout_flag,
  input  logic            timeout_clr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;  // 1 = master 1 owned last
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q, flag_d;

  logic            req0, req1;
  logic            own_stb;
  logic            cnt_hit;
  logic            abort;

  assign req0    = m0_cyc & m0_stb;
  assign req1    = m1_cyc & m1_stb;
  assign own_stb = (state_q == StOwn0) ? m0_stb :
                   (state_q == StOwn1) ? m1_stb : 1'b0;
  assign cnt_hit = (cnt_q == CW'(TIMEOUT));
  // A slave ack in the same cycle the watchdog fires wins: it is a normal ack.
  assign abort   = own_stb & cnt_hit & ~s_ack;

  assign timeout_flag = flag_q;

  // State, arbitration history, watchdog and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
    end
  end

  // Next-state logic: arbitration in idle, release when the owner drops cyc.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = (prio_host || !last_owner_q) ? StOwn1 : StOwn0;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc) begin
          state_d      = StIdle;
          last_owner_d = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1_cyc) begin
          state_d      = StIdle;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog counter and sticky timeout flag (a new abort beats a clear).
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle || s_ack || abort) begin
      cnt_d = '0;
    end else if (own_stb) begin
      cnt_d = cnt_q + 1'b1;
    end

    flag_d = flag_q;
    if (abort) begin
      flag_d = 1'b1;
    end else if (timeout_clr) begin
      flag_d = 1'b0;
    end
  end

  // Output steering: only the owner reaches the slave and sees its responses.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_ack   = 1'b0;
    m0_dat_o = '0;
    m1_ack   = 1'b0;
    m1_dat_o = '0;
    grant    = 2'b00;
    unique case (state_q)
      StOwn0: begin
        grant    = 2'b01;
        s_cyc    = m0_cyc & ~abort;
        s_stb    = m0_stb & ~abort;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_i;
        m0_ack   = s_ack | abort;
        m0_dat_o = abort ? '1 : s_dat_i;
      end
      StOwn1: begin
        grant    = 2'b10;
        s_cyc    = m1_cyc & ~abort;
        s_stb    = m1_stb & ~abort;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_i;
        m1_ack   = s_ack | abort;
        m1_dat_o = abort ? '1 : s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising edge.
module tb_wb_arbiter2;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]    m0_sel, m1_sel, s_sel;
  logic [31:0]   m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
  logic          m0_ack, m1_ack;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [31:0]   s_adr, s_dat_o, s_dat_i;
  logic          prio_host, timeout_clr, timeout_flag;
  logic [1:0]    grant;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m0_cyc       (m0_cyc),
    .m0_stb       (m0_stb),
    .m0_we        (m0_we),
    .m0_sel       (m0_sel),
    .m0_adr       (m0_adr),
    .m0_dat_i     (m0_dat_i),
    .m0_dat_o     (m0_dat_o),
    .m0_ack       (m0_ack),
    .m1_cyc       (m1_cyc),
    .m1_stb       (m1_stb),
    .m1_we        (m1_we),
    .m1_sel       (m1_sel),
    .m1_adr       (m1_adr),
    .m1_dat_i     (m1_dat_i),
    .m1_dat_o     (m1_dat_o),
    .m1_ack       (m1_ack),
    .s_cyc        (s_cyc),
    .s_stb        (s_stb),
    .s_we         (s_we),
    .s_sel        (s_sel),
    .s_adr        (s_adr),
    .s_dat_o      (s_dat_o),
    .s_dat_i      (s_dat_i),
    .s_ack        (s_ack),
    .prio_host    (prio_host),
    .grant        (grant),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat_i = d;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat_i = d;
  endtask

  initial begin
    reset_n = 1'b0; prio_host = 1'b0; timeout_clr = 1'b0;
    s_ack = 1'b0; s_dat_i = '0; m0_sel = 4'hF; m1_sel = 4'hF;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst grant", 32'(grant), 0);
    check_eq("rst s_cyc", 32'(s_cyc), 0);
    check_eq("rst s_stb", 32'(s_stb), 0);
    check_eq("rst flag", 32'(timeout_flag), 0);
    check_eq("rst acks", {30'd0, m1_ack, m0_ack}, 0);
    check_eq("rst m0_dat_o", m0_dat_o, 0);

    // m0 single read, slave acks two cycles after stb
    @(negedge clk); reset_n = 1'b1; set_m0(1, 1, 0, 32'h100, 0);
    #1; check_eq("A lat grant", 32'(grant), 0); check_eq("A lat stb", 32'(s_stb), 0);
    @(negedge clk); #1;
    check_eq("A grant", 32'(grant), 32'h1);
    check_eq("A s_stb", 32'(s_stb), 1);
    check_eq("A s_adr", s_adr, 32'h100);
    check_eq("A s_sel", 32'(s_sel), 32'hF);
    check_eq("A no ack1", 32'(m0_ack), 0);
    @(negedge clk); #1; check_eq("A no ack2", 32'(m0_ack), 0);
    @(negedge clk); s_ack = 1'b1; s_dat_i = 32'h12345678; #1;
    check_eq("A m0_ack", 32'(m0_ack), 1);
    check_eq("A m0_dat_o", m0_dat_o, 32'h12345678);
    check_eq("A m1_ack", 32'(m1_ack), 0);
    check_eq("A m1_dat_o", m1_dat_o, 0);
    @(negedge clk); s_ack = 1'b0; s_dat_i = '0; set_m0(0, 0, 0, 0, 0); #1;
    check_eq("A drop s_cyc", 32'(s_cyc), 0);
    check_eq("A drop ack", 32'(m0_ack), 0);
    @(negedge clk); #1; check_eq("A idle", 32'(grant), 0);

    // both request right after reset, round robin
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    set_m0(1, 1, 1, 32'h200, 32'hAAAA0001);
    set_m1(1, 1, 1, 32'h300, 32'hBBBB0001);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("B1 grant", 32'(grant), 32'h1);
    check_eq("B1 s_adr", s_adr, 32'h200);
    check_eq("B1 s_dat_o", s_dat_o, 32'hAAAA0001);
    check_eq("B1 s_we", 32'(s_we), 1);
    check_eq("B1 m0_ack", 32'(m0_ack), 1);
    check_eq("B1 m1_ack", 32'(m1_ack), 0);
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0); #1;
    check_eq("B1 rel s_cyc", 32'(s_cyc), 0);
    @(negedge clk); #1; check_eq("B gap idle", 32'(grant), 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("B2 grant", 32'(grant), 32'h2);
    check_eq("B2 s_adr", s_adr, 32'h300);
    check_eq("B2 s_dat_o", s_dat_o, 32'hBBBB0001);
    check_eq("B2 m1_ack", 32'(m1_ack), 1);
    check_eq("B2 m0_ack", 32'(m0_ack), 0);
    @(negedge clk); s_ack = 1'b0; set_m1(0, 0, 0, 0, 0); set_m0(1, 1, 0, 32'h210, 0);
    @(negedge clk); set_m1(1, 1, 0, 32'h310, 0); #1;
    check_eq("B3 idle", 32'(grant), 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("B3 grant", 32'(grant), 32'h1);
    check_eq("B3 s_adr", s_adr, 32'h210);
    check_eq("B3 m0_ack", 32'(m0_ack), 1);
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1; check_eq("B end idle", 32'(grant), 0);

    // host priority
    @(negedge clk); prio_host = 1'b1;
    set_m0(1, 1, 0, 32'h220, 0); set_m1(1, 1, 0, 32'h320, 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("C1 grant", 32'(grant), 32'h2);
    check_eq("C1 s_adr", s_adr, 32'h320);
    @(negedge clk); s_ack = 1'b0; #1; check_eq("C1 hold", 32'(grant), 32'h2);
    @(negedge clk); set_m1(0, 0, 0, 0, 0); #1; check_eq("C1 rel s_cyc", 32'(s_cyc), 0);
    @(negedge clk); set_m1(1, 1, 0, 32'h320, 0); #1; check_eq("C idle", 32'(grant), 0);
    @(negedge clk); s_ack = 1'b1; #1; check_eq("C2 grant", 32'(grant), 32'h2);
    @(negedge clk); s_ack = 1'b0; set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1; check_eq("C idle2", 32'(grant), 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("C3 grant", 32'(grant), 32'h1);
    check_eq("C3 s_adr", s_adr, 32'h220);
    check_eq("C3 m0_ack", 32'(m0_ack), 1);
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0); prio_host = 1'b0;
    @(negedge clk); #1; check_eq("C end idle", 32'(grant), 0);

    // locked burst of three writes while m1 waits
    @(negedge clk); set_m0(1, 1, 1, 32'h0, 32'hD0);
    @(negedge clk); set_m1(1, 1, 1, 32'hDEAD0000, 32'h11); s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); set_m0(1, 1, 1, 32'(4 * i), 32'(32'hD0 + 4 * i));
      end
      #1;
      check_eq("D grant", 32'(grant), 32'h1);
      check_eq("D s_adr", s_adr, 32'(4 * i));
      check_eq("D s_dat_o", s_dat_o, 32'(32'hD0 + 4 * i));
      check_eq("D m0_ack", 32'(m0_ack), 1);
      check_eq("D m1_ack", 32'(m1_ack), 0);
    end
    @(negedge clk); s_ack = 1'b0; set_m0(0, 0, 0, 0, 0); #1;
    check_eq("D rel grant", 32'(grant), 32'h1);
    check_eq("D rel s_cyc", 32'(s_cyc), 0);
    @(negedge clk); #1; check_eq("D gap", 32'(grant), 0);
    @(negedge clk); s_ack = 1'b1; #1;
    check_eq("D m1 grant", 32'(grant), 32'h2);
    check_eq("D m1 s_adr", s_adr, 32'hDEAD0000);
    check_eq("D m1_ack", 32'(m1_ack), 1);
    @(negedge clk); s_ack = 1'b0; set_m1(0, 0, 0, 0, 0);
    @(negedge clk); #1; check_eq("D end idle", 32'(grant), 0);

    // m1 write, slave never acks: abort after four stalled cycles
    @(negedge clk); set_m1(1, 1, 1, 32'h400, 32'h5);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      check_eq("E stall ack", 32'(m1_ack), 0);
      check_eq("E stall s_cyc", 32'(s_cyc), 1);
    end
    @(negedge clk); #1;
    check_eq("E abort ack", 32'(m1_ack), 1);
    check_eq("E abort dat", m1_dat_o, 32'hFFFFFFFF);
    check_eq("E abort s_cyc", 32'(s_cyc), 0);
    check_eq("E abort s_stb", 32'(s_stb), 0);
    check_eq("E abort m0_ack", 32'(m0_ack), 0);
    @(negedge clk); set_m1(0, 0, 0, 0, 0); #1;
    check_eq("E flag set", 32'(timeout_flag), 1);
    check_eq("E post ack", 32'(m1_ack), 0);
    @(negedge clk); timeout_clr = 1'b1; #1; check_eq("E flag held", 32'(timeout_flag), 1);
    @(negedge clk); timeout_clr = 1'b0; #1; check_eq("E flag clr", 32'(timeout_flag), 0);

    // m0 timeout with a coincident clear, then reset mid-transfer
    @(negedge clk); set_m0(1, 1, 0, 32'h500, 0);
    repeat (4) @(negedge clk);
    @(negedge clk); timeout_clr = 1'b1; #1;
    check_eq("F abort ack", 32'(m0_ack), 1);
    check_eq("F abort dat", m0_dat_o, 32'hFFFFFFFF);
    @(negedge clk); timeout_clr = 1'b0; reset_n = 1'b0; #1;
    check_eq("F set wins", 32'(timeout_flag), 1);
    check_eq("F owner", 32'(grant), 32'h1);
    @(negedge clk); #1;
    check_eq("F rst grant", 32'(grant), 0);
    check_eq("F rst s_cyc", 32'(s_cyc), 0);
    check_eq("F rst flag", 32'(timeout_flag), 0);
    check_eq("F rst ack", 32'(m0_ack), 0);
    @(negedge clk); reset_n = 1'b1; set_m0(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
